// File: rtl/flyhigh_pkg.sv
// flyhigh_pkg: screen geometry, coordinate widths and the obstacle FSM state type
// shared by the flyhigh game blocks.
package flyhigh_pkg;

  localparam int H_VISIBLE = 640;
  localparam int V_VISIBLE = 480;
  localparam int X_W       = 10;  // visible pixel column
  localparam int Y_W       = 9;   // visible pixel row
  localparam int C_W       = 12;  // object / player coordinates

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_CRASH = 1'b1
  } fsm_state_t;

endpackage

// File: rtl/lfsr16.sv
// lfsr16: 16-bit maximal-length Fibonacci LFSR, x^16+x^14+x^13+x^11+1,
// right-shifting form with seed 16'hACE1. Advances once per step enable.
module lfsr16 (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_step,
  output logic [15:0] o_state
);

  logic [15:0] r_state;
  logic        w_fb;

  // Taps 16,14,13,11 map to bits 0,2,3,5 in the right-shifting form.
  assign w_fb = r_state[0] ^ r_state[2] ^ r_state[3] ^ r_state[5];

  // Shift register; reset loads the nonzero seed so the sequence never locks up.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= 16'hACE1;
    end else if (i_step) begin
      r_state <= {w_fb, r_state[15:1]};
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/obstacle_field.sv
// obstacle_field: N_OBS scrolling column obstacles, each with a vertical gap.
// Columns move left on every animate frame, new ones spawn periodically at the
// right edge, and o_obstacle reports the current pixel one pixel strobe later.
// Optional feature: define OBSTACLE_COLLIDE_EN to add the player collision
// latch and the CRASH freeze; without it o_collide/o_crashed are tied low.
module obstacle_field
  import flyhigh_pkg::*;
#(
  parameter int N_OBS        = 4,
  parameter int OBS_W        = 32,
  parameter int GAP_H        = 120,
  parameter int SPEED        = 2,
  parameter int SPAWN_PERIOD = 90,
  parameter int CRASH_FRAMES = 60
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_pix_stb,
  input  logic           i_animate,
  input  logic [X_W-1:0] i_x,
  input  logic [Y_W-1:0] i_y,
  input  logic [C_W-1:0] i_player_x1,
  input  logic [C_W-1:0] i_player_x2,
  input  logic [C_W-1:0] i_player_y1,
  input  logic [C_W-1:0] i_player_y2,
  output logic           o_obstacle,
  output logic           o_collide,
  output logic           o_crashed
);

  localparam int FC_W    = $clog2(SPAWN_PERIOD + 1);
  localparam int CC_W    = $clog2(CRASH_FRAMES + 1);
  localparam int GAP_MOD = V_VISIBLE - GAP_H;

  localparam logic signed [C_W-1:0] L_SPEED   = C_W'(SPEED);
  localparam logic signed [C_W-1:0] L_OBS_W   = C_W'(OBS_W);
  localparam logic signed [C_W-1:0] L_KILL_X  = C_W'(-OBS_W);
  localparam logic signed [C_W-1:0] L_SPAWN_X = C_W'(H_VISIBLE);
  localparam logic [Y_W:0]          L_GAP_H   = (Y_W + 1)'(GAP_H);

  fsm_state_t              r_state;
  logic [N_OBS-1:0]        r_act;
  logic signed [C_W-1:0]   r_x   [N_OBS];
  logic [Y_W-1:0]          r_gap [N_OBS];
  logic [FC_W-1:0]         r_frame;
  logic [CC_W-1:0]         r_crash_cnt;
  logic                    r_obstacle;

  logic [15:0]             w_lfsr;
  logic [Y_W-1:0]          w_gap_new;
  logic signed [C_W-1:0]   w_px;
  logic signed [C_W-1:0]   w_x_mv [N_OBS];
  logic [N_OBS-1:0]        w_dead;
  logic [N_OBS-1:0]        w_spawn_sel;
  logic                    w_spawn_now;
  logic                    w_hit;
  logic                    w_player;
  logic                    w_crash_go;
  logic                    w_unused;

  lfsr16 u_lfsr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_step  (i_animate),
    .o_state (w_lfsr)
  );

  // Gap position for a newly spawned column, taken from the pre-step LFSR value.
  assign w_gap_new   = Y_W'({23'd0, w_lfsr[8:0]} % 32'(GAP_MOD));
  assign w_px        = $signed(C_W'(i_x));
  assign w_spawn_now = (r_frame == FC_W'(SPAWN_PERIOD - 1));
  // Lowest-index inactive slot as a one-hot; all-ones r_act wraps to zero so a full field drops the spawn.
  assign w_spawn_sel = ~r_act & (r_act + N_OBS'(1));

  // Next x for each slot after one move, and whether it has fully left the screen.
  always_comb begin
    for (int i = 0; i < N_OBS; i++) begin
      w_x_mv[i] = r_x[i] - L_SPEED;
      w_dead[i] = (w_x_mv[i] <= L_KILL_X);
    end
  end

  // Current pixel lies in a column of some active slot but outside that slot's gap.
  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < N_OBS; i++) begin
      if (r_act[i] && (w_px >= r_x[i]) && (w_px < r_x[i] + L_OBS_W) &&
          (({1'b0, i_y} < {1'b0, r_gap[i]}) ||
           ({1'b0, i_y} >= ({1'b0, r_gap[i]} + L_GAP_H)))) begin
        w_hit = 1'b1;
      end
    end
  end

  // Player box uses strict bounds, matching how the compositor draws it.
  assign w_player = (C_W'(i_x) > i_player_x1) && (C_W'(i_x) < i_player_x2) &&
                    (C_W'(i_y) > i_player_y1) && (C_W'(i_y) < i_player_y2);

`ifdef OBSTACLE_COLLIDE_EN
  logic r_latch;

  // Remember any overlap seen during the frame; consumed on the next animate.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_latch <= 1'b0;
    end else if ((r_state != ST_RUN) || w_crash_go) begin
      r_latch <= 1'b0;
    end else if (i_pix_stb && w_hit && w_player) begin
      r_latch <= 1'b1;
    end
  end

  assign w_crash_go = i_animate && r_latch && (r_state == ST_RUN);
  assign o_collide  = w_crash_go;
  assign o_crashed  = (r_state == ST_CRASH);
  assign w_unused   = ^w_lfsr[15:9];
`else
  assign w_crash_go = 1'b0;
  assign o_collide  = 1'b0;
  assign o_crashed  = 1'b0;
  assign w_unused   = ^{w_lfsr[15:9], w_player};
`endif

  // Obstacle pixel output, advanced only on pixel strobes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_obstacle <= 1'b0;
    end else if (i_pix_stb) begin
      r_obstacle <= w_hit;
    end
  end

  assign o_obstacle = r_obstacle;

  // RUN/CRASH state machine with slot movement, spawning and frame counting.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_RUN;
      r_act       <= '0;
      r_frame     <= '0;
      r_crash_cnt <= '0;
      for (int i = 0; i < N_OBS; i++) begin
        r_x[i]   <= '0;
        r_gap[i] <= '0;
      end
    end else if (i_animate) begin
      case (r_state)
        ST_RUN: begin
          if (w_crash_go) begin
            r_state     <= ST_CRASH;
            r_crash_cnt <= '0;
          end else begin
            // Existing slots move; a spawned slot starts untouched at the right edge.
            for (int i = 0; i < N_OBS; i++) begin
              if (r_act[i]) begin
                r_x[i] <= w_x_mv[i];
                if (w_dead[i]) r_act[i] <= 1'b0;
              end else if (w_spawn_now && w_spawn_sel[i]) begin
                r_act[i] <= 1'b1;
                r_x[i]   <= L_SPAWN_X;
                r_gap[i] <= w_gap_new;
              end
            end
            if (w_spawn_now) r_frame <= '0;
            else             r_frame <= r_frame + FC_W'(1);
          end
        end
        ST_CRASH: begin
          if (r_crash_cnt == CC_W'(CRASH_FRAMES - 1)) begin
            r_state     <= ST_RUN;
            r_act       <= '0;
            r_frame     <= '0;
            r_crash_cnt <= '0;
            for (int i = 0; i < N_OBS; i++) begin
              r_x[i]   <= '0;
              r_gap[i] <= '0;
            end
          end else begin
            r_crash_cnt <= r_crash_cnt + CC_W'(1);
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_obstacle_field.sv
// tb_obstacle_field: randomized pixel/animate stimulus against a behavioural
// model of the obstacle field, with a queue-based scoreboard. Two instances
// run side by side: default parameters, and N_OBS=2 so the field fills up.
module tb_obstacle_field;

  localparam int NI  = 2;
  localparam int W   = 32;
  localparam int GH  = 120;
  localparam int SP  = 2;
  localparam int PER = 90;
  localparam int CF  = 60;
`ifdef OBSTACLE_COLLIDE_EN
  localparam bit COLL = 1'b1;
`else
  localparam bit COLL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        pix_stb = 1'b0;
  logic        animate = 1'b0;
  logic [9:0]  px = '0;
  logic [8:0]  py = '0;
  logic [11:0] p_x1 = 12'd2000, p_x2 = 12'd2001, p_y1 = 12'd2000, p_y2 = 12'd2001;
  logic [1:0]  obs, col, crs;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  obstacle_field u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_stb(pix_stb), .i_animate(animate),
    .i_x(px), .i_y(py),
    .i_player_x1(p_x1), .i_player_x2(p_x2), .i_player_y1(p_y1), .i_player_y2(p_y2),
    .o_obstacle(obs[0]), .o_collide(col[0]), .o_crashed(crs[0])
  );

  obstacle_field #(.N_OBS(2)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_stb(pix_stb), .i_animate(animate),
    .i_x(px), .i_y(py),
    .i_player_x1(p_x1), .i_player_x2(p_x2), .i_player_y1(p_y1), .i_player_y2(p_y2),
    .o_obstacle(obs[1]), .o_collide(col[1]), .o_crashed(crs[1])
  );

  // ---------------- behavioural model ----------------
  int m_nobs [NI] = '{4, 2};
  int m_act  [NI][4];
  int m_x    [NI][4];
  int m_gap  [NI][4];
  int m_frame[NI];
  int m_run  [NI];
  int m_crash[NI];
  int m_latch[NI];
  int m_lfsr;

  logic [1:0] q_obs[$];
  logic [3:0] q_anim[$];

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      for (int s = 0; s < 4; s++) begin
        m_act[k][s] = 0; m_x[k][s] = 0; m_gap[k][s] = 0;
      end
      m_frame[k] = 0; m_run[k] = 1; m_crash[k] = 0; m_latch[k] = 0;
    end
    m_lfsr = 16'hACE1;
  endtask

  function automatic bit m_hit(int k, int x, int y);
    for (int s = 0; s < m_nobs[k]; s++)
      if (m_act[k][s] != 0 && x >= m_x[k][s] && x < m_x[k][s] + W &&
          (y < m_gap[k][s] || y >= m_gap[k][s] + GH))
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_player(int x, int y);
    return x > int'(p_x1) && x < int'(p_x2) && y > int'(p_y1) && y < int'(p_y2);
  endfunction

  // One clock of the model: record expected outputs, then apply the frame rules.
  task automatic model_cycle(input bit stb, input bit anim, input int x, input int y);
    logic [1:0] e_obs, e_col, e_crs;
    int gap_new;
    int b;
    gap_new = (m_lfsr % 512) % (480 - GH);
    for (int k = 0; k < NI; k++) begin
      bit h;
      bit go;
      h = m_hit(k, x, y);
      go = COLL && anim && m_run[k] != 0 && m_latch[k] != 0;
      e_obs[k] = h;
      e_col[k] = go;
      e_crs[k] = (m_run[k] == 0);
      if (m_run[k] == 0 || go) m_latch[k] = 0;
      else if (COLL && stb && h && m_player(x, y)) m_latch[k] = 1;
      if (anim) begin
        if (go) begin
          m_run[k] = 0; m_crash[k] = 0;
        end else if (m_run[k] != 0) begin
          int fr;
          fr = -1;
          for (int s = 0; s < m_nobs[k]; s++)
            if (m_act[k][s] == 0 && fr < 0) fr = s;
          for (int s = 0; s < m_nobs[k]; s++)
            if (m_act[k][s] != 0) begin
              m_x[k][s] = m_x[k][s] - SP;
              if (m_x[k][s] + W <= 0) m_act[k][s] = 0;
            end
          m_frame[k]++;
          if (m_frame[k] == PER) begin
            m_frame[k] = 0;
            if (fr >= 0) begin
              m_act[k][fr] = 1; m_x[k][fr] = 640; m_gap[k][fr] = gap_new;
            end
          end
        end else begin
          m_crash[k]++;
          if (m_crash[k] == CF) begin
            for (int s = 0; s < 4; s++) begin
              m_act[k][s] = 0; m_x[k][s] = 0; m_gap[k][s] = 0;
            end
            m_frame[k] = 0; m_run[k] = 1;
          end
        end
      end
    end
    if (stb) q_obs.push_back(e_obs);
    if (anim) begin
      q_anim.push_back({e_col, e_crs});
      b = (m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1;
      m_lfsr = (m_lfsr >> 1) | (b << 15);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit stb, input bit anim, input int x, input int y);
    @(posedge clk); #1;
    pix_stb = stb; animate = anim; px = 10'(x); py = 9'(y);
    model_cycle(stb, anim, x, y);
  endtask

  task automatic pick(output int x, output int y);
    int offs_x[7] = '{-1, 0, 1, 5, 30, 31, 32};
    int offs_y[7] = '{-1, 0, 10, 119, 120, -30, 150};
    int k, s;
    x = int'($urandom_range(0, 639));
    y = int'($urandom_range(0, 479));
    if ($urandom_range(0, 3) != 0) begin
      k = int'($urandom_range(0, NI - 1));
      s = int'($urandom_range(0, m_nobs[k] - 1));
      if (m_act[k][s] != 0) begin
        x = m_x[k][s] + offs_x[$urandom_range(0, 6)];
        y = m_gap[k][s] + offs_y[$urandom_range(0, 6)];
      end
    end
    if (x < 0) x = 0;
    if (x > 639) x = 639;
    if (y < 0) y = 0;
    if (y > 479) y = 479;
  endtask

  task automatic frame(input int npix);
    int x, y;
    for (int i = 0; i < npix; i++) begin
      pick(x, y);
      drive($urandom_range(0, 3) != 0, 1'b0, x, y);
    end
    pick(x, y);
    drive($urandom_range(0, 1) == 1, 1'b1, x, y);
  endtask

  task automatic check_reset_outputs();
    for (int k = 0; k < NI; k++) begin
      check($sformatf("reset_obstacle%0d", k), int'(obs[k]), 0);
      check($sformatf("reset_collide%0d", k), int'(col[k]), 0);
      check($sformatf("reset_crashed%0d", k), int'(crs[k]), 0);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  logic stb_d = 1'b0;
  always @(posedge clk) stb_d <= pix_stb;

  always @(negedge clk) begin
    logic [1:0] eo;
    logic [3:0] ea;
    if (rst_n) begin
      if (stb_d) begin
        if (q_obs.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL obstacle_queue: output strobe with no expectation at %0t", $time);
        end else begin
          eo = q_obs.pop_front();
          for (int k = 0; k < NI; k++)
            check($sformatf("obstacle%0d", k), int'(obs[k]), int'(eo[k]));
        end
      end
      if (animate) begin
        if (q_anim.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL animate_queue: animate with no expectation at %0t", $time);
        end else begin
          ea = q_anim.pop_front();
          for (int k = 0; k < NI; k++) begin
            check($sformatf("collide%0d", k), int'(col[k]), int'(ea[2 + k]));
            check($sformatf("crashed%0d", k), int'(crs[k]), int'(ea[k]));
          end
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int bx, g, y;
    #1 rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1 rst_n = 1'b1;

    // Reach the first spawn and follow the new column in.
    for (int f = 0; f < 100; f++) frame(int'($urandom_range(2, 6)));

    // Park the player over slot 0, outside its gap, and strobe pixels inside the box.
    drive(1'b0, 1'b0, 0, 0);
    bx = m_x[0][0];
    g  = m_gap[0][0];
    p_x1 = 12'(bx + 5);
    p_x2 = 12'(bx + 15);
    if (g >= 20) begin p_y1 = 12'(g - 20); p_y2 = 12'(g - 1); end
    else begin p_y1 = 12'(g + GH); p_y2 = 12'(g + GH + 20); end
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, bx + 10, int'(p_y1) + 5);
    drive(1'b0, 1'b1, 0, 0);
    drive(1'b0, 1'b0, 0, 0);
    p_x1 = 12'd2000; p_x2 = 12'd2001; p_y1 = 12'd2000; p_y2 = 12'd2001;

    // Crash freeze (when enabled), then long scrolling with kills and full-field drops.
    for (int f = 0; f < 600; f++) frame(int'($urandom_range(2, 6)));

    // Reset in the middle of a frame.
    for (int i = 0; i < 3; i++) begin
      int x0, y0;
      pick(x0, y0);
      drive(1'b1, 1'b0, x0, y0);
    end
    drive(1'b0, 1'b0, 0, 0);
    @(negedge clk); #1 rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1 rst_n = 1'b1;

    // First spawn lands exactly SPAWN_PERIOD animates after release, then moves by SPEED.
    for (int f = 0; f < 90; f++) frame(2);
    y = (m_gap[0][0] > 0) ? m_gap[0][0] - 1 : m_gap[0][0] + GH;
    drive(1'b1, 1'b0, 639, y);
    drive(1'b0, 1'b1, 0, 0);
    drive(1'b1, 1'b0, 639, y);
    drive(1'b1, 1'b0, 638, y);
    drive(1'b1, 1'b0, 637, y);
    drive(1'b1, 1'b0, 639, m_gap[0][0] + 10);
    for (int f = 0; f < 5; f++) frame(3);

    drive(1'b0, 1'b0, 0, 0);
    drive(1'b0, 1'b0, 0, 0);
    @(negedge clk);
    check("obstacle_queue_drained", q_obs.size(), 0);
    check("animate_queue_drained", q_anim.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: bench did not finish, %0d tests run", n_tests);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/obstacle_field.md
OBSTACLE_FIELD -- requirements
Module: obstacle_field

Interface
REQ-001 The block SHALL have parameter N_OBS, default 4, meaning number of obstacle slots (1-8).
REQ-002 The block SHALL have parameter OBS_W, default 32, meaning obstacle width in pixels.
REQ-003 The block SHALL have parameter GAP_H, default 120, meaning vertical gap height in pixels.
REQ-004 The block SHALL have parameter SPEED, default 2, meaning leftward pixels moved per animate frame.
REQ-005 The block SHALL have parameter SPAWN_PERIOD, default 90, meaning frames between spawn attempts.
REQ-006 The block SHALL have parameter CRASH_FRAMES, default 60, meaning freeze length after collision.
REQ-007 The block SHALL have port i_clk, input, 1 bit, the 100 MHz board clock.
REQ-008 The block SHALL have port i_rst_n, input, 1 bit, the reset; one clock, reset asynchronous and active-low.
REQ-009 The block SHALL have port i_pix_stb, input, 1 bit, the 25 MHz pixel strobe.
REQ-010 The block SHALL have port i_animate, input, 1 bit, the one-cycle end-of-frame pulse.
REQ-011 The block SHALL have ports i_x (10 bits) and i_y (9 bits), inputs, the current visible pixel.
REQ-012 The block SHALL have ports i_player_x1, i_player_x2, i_player_y1 and i_player_y2, inputs, 12 bits each, the player box.
REQ-013 The block SHALL have port o_obstacle, output, 1 bit, meaning the current pixel is inside an obstacle.
REQ-014 The block SHALL have port o_collide, output, 1 bit, a one-cycle pulse on a crash.
REQ-015 The block SHALL have port o_crashed, output, 1 bit, high while in the CRASH state.

Function
REQ-016 Each slot SHALL hold: active flag, x (12-bit signed, left edge), gap_y (9-bit, top of gap).
REQ-017 An obstacle pixel SHALL be one where i_x is in [x, x+OBS_W) and i_y is outside [gap_y, gap_y+GAP_H), for any active slot.
REQ-018 o_obstacle SHALL be registered and update only on cycles with i_pix_stb high, giving 1 pixel-strobe latency.
REQ-019 The FSM SHALL have the states RUN and CRASH.
REQ-020 RUN: on each i_animate, every active slot SHALL have x reduced by SPEED; a slot whose x+OBS_W <= 0 after the move SHALL become inactive in that same cycle.
REQ-021 RUN: a frame counter SHALL count i_animate pulses; at SPAWN_PERIOD-1 it wraps to 0 and spawns into the lowest-index free slot with x=640 and gap_y = (lfsr[8:0] mod (480-GAP_H)).
REQ-022 When every slot is active, the spawn SHALL be dropped silently and the counter SHALL still wrap.
REQ-023 When a move and a spawn fall on the same i_animate, the move SHALL apply to existing slots only; the new slot SHALL start at exactly 640.
REQ-024 The LFSR SHALL be 16-bit maximal (x^16+x^14+x^13+x^11+1), step once per i_animate, and hold a nonzero seed 16'hACE1 at reset.
REQ-025 The collision latch SHALL set on any pixel-strobe cycle where the obstacle pixel and the player pixel (strict inequalities, as the compositor uses) are both true.
REQ-026 On i_animate with the latch set in RUN, o_collide SHALL pulse for that cycle, the FSM SHALL enter CRASH, and the latch SHALL clear.
REQ-027 CRASH: slots SHALL be frozen (no move, no spawn) and o_crashed SHALL be high; after CRASH_FRAMES i_animate pulses, all slots SHALL clear, the frame counter SHALL reset, and the FSM SHALL return to RUN.
REQ-028 The collision latch SHALL be ignored and held clear while in CRASH.

Reset
REQ-029 Asserting i_rst_n low SHALL asynchronously force: all slots inactive, x=0, gap_y=0, counters 0, FSM=RUN, latch 0, o_obstacle=0, o_collide=0, o_crashed=0, LFSR=16'hACE1.
REQ-030 Reset asserted mid-frame or mid-CRASH SHALL abandon all state; the first spawn SHALL occur SPAWN_PERIOD animate pulses after release.

Configuration
REQ-031 With the macro OBSTACLE_COLLIDE_EN defined, REQ-025 to REQ-028 SHALL apply.
REQ-032 Without OBSTACLE_COLLIDE_EN, the collision latch and CRASH state SHALL be absent, o_collide and o_crashed SHALL be tied 0, and the FSM SHALL remain in RUN.

Structure
REQ-033 Shared package flyhigh_pkg SHALL hold: H_VISIBLE=640, V_VISIBLE=480, the coordinate widths (10/9/12), and the FSM state typedef.
REQ-034 The LFSR SHALL be the sub-module lfsr16 (clock, reset, step enable, 16-bit state out).

Verification
REQ-035 Reset release, 90 animate pulses -> slot0 active, x=640, gap_y in [0,359]; after 1 more pulse x=638.
REQ-036 Slot at x=-30 with OBS_W=32 and SPEED=2, one animate -> slot inactive in that cycle.
REQ-037 All 4 slots active at a spawn tick -> no slot changes except the move; counter wraps to 0.
REQ-038 Player box overlapping a column outside its gap during a frame -> o_collide high for exactly the animate cycle; o_crashed high for 60 frames; then all slots inactive and FSM in RUN.
REQ-039 Pixel at (x+5, gap_y+10) -> o_obstacle=0; pixel at (x+5, gap_y-1) -> o_obstacle=1, one pix_stb later.
REQ-040 Build without OBSTACLE_COLLIDE_EN and repeat the overlap stimulus -> o_collide=0 and scrolling continues.
